// File: rtl/mem_responder_if.sv
// Request/grant bundle between the pipeline requesters (fetch and load/store)
// and the memory responder.
interface mem_responder_if;
    logic        instr_req_ip;
    logic [31:0] instr_addr_ip;
    logic        instr_gnt_op;
    logic [31:0] instr_rdata_op;
    logic        data_req_ip;
    logic        data_we_ip;
    logic [2:0]  data_func3_ip;
    logic [31:0] data_addr_ip;
    logic [31:0] data_wdata_ip;
    logic        data_gnt_op;
    logic [31:0] data_rdata_op;
    logic        data_err_op;

    modport master (
        output instr_req_ip, instr_addr_ip,
        output data_req_ip, data_we_ip, data_func3_ip, data_addr_ip, data_wdata_ip,
        input  instr_gnt_op, instr_rdata_op,
        input  data_gnt_op, data_rdata_op, data_err_op
    );

    modport slave (
        input  instr_req_ip, instr_addr_ip,
        input  data_req_ip, data_we_ip, data_func3_ip, data_addr_ip, data_wdata_ip,
        output instr_gnt_op, instr_rdata_op,
        output data_gnt_op, data_rdata_op, data_err_op
    );
endinterface

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: arbitrates instruction and data ports
// (data first), performs RISC-V sized loads/stores and grants for one cycle.
module mem_responder #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           mem_en,
    mem_responder_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    state_t          state_r, next_state_s;
    logic [3:0]      cnt_r;
    logic            sel_data_r, we_r;
    logic [2:0]      func3_r;
    logic [AW+1:0]   addr_r;
    logic [31:0]     wdata_r;
    logic            instr_gnt_r, data_gnt_r, data_err_r;
    logic [31:0]     instr_rdata_r, data_rdata_r;
    logic [31:0]     mem_r [DEPTH];

    logic            accept_s, cur_data_s, cur_we_s, resp_err_s, wr_en_s, unused_addr_s;
    logic [2:0]      cur_func3_s;
    logic [AW+1:0]   cur_addr_s;
    logic [31:0]     rd_word_s, resp_rdata_s, wr_mask_s, wr_lane_s;
    logic [3:0]      wr_be_s;

    function automatic logic access_err(input logic we, input logic [2:0] f3, input logic [1:0] off);
        logic e;
        case (f3)
            3'b000:  e = 1'b0;
            3'b001:  e = off[0];
            3'b010:  e = (off != 2'b00);
            3'b100:  e = we;
            3'b101:  e = we | off[0];
            default: e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] load_ext(input logic [31:0] w, input logic [2:0] f3, input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (off)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = w;
            3'b100:  r = {24'h000000, b};
            3'b101:  r = {16'h0000, h};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3)
            3'b000:  be = 4'b0001 << off;
            3'b001:  be = off[1] ? 4'b1100 : 4'b0011;
            3'b010:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] store_lane(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] l;
        case (f3)
            3'b000:  l = {4{wd[7:0]}};
            3'b001:  l = {2{wd[15:0]}};
            default: l = wd;
        endcase
        return l;
    endfunction

    assign accept_s      = (state_r == IDLE) && mem_en && (bus.data_req_ip || bus.instr_req_ip);
    assign unused_addr_s = ^{bus.data_addr_ip[31:AW+2], bus.instr_addr_ip[31:AW+2]};

    // Operands of the transaction in flight: live inputs while idle (latency 1 grants straight from IDLE), latched copy otherwise
    always_comb begin
        cur_data_s  = sel_data_r;
        cur_we_s    = we_r;
        cur_func3_s = func3_r;
        cur_addr_s  = addr_r;
        if (state_r == IDLE) begin
            cur_data_s  = bus.data_req_ip;
            cur_we_s    = bus.data_req_ip & bus.data_we_ip;
            cur_func3_s = bus.data_req_ip ? bus.data_func3_ip : 3'b010;
            cur_addr_s  = bus.data_req_ip ? bus.data_addr_ip[AW+1:0] : bus.instr_addr_ip[AW+1:0];
        end else begin
            cur_data_s  = sel_data_r;
        end
    end

    assign rd_word_s = mem_r[cur_addr_s[AW+1:2]];

    // Response value and error flag computed for the cycle entering RESP
    always_comb begin
        resp_err_s   = 1'b0;
        resp_rdata_s = 32'h0000_0000;
        if (!cur_data_s) begin
            resp_rdata_s = rd_word_s;
        end else if (access_err(cur_we_s, cur_func3_s, cur_addr_s[1:0])) begin
            resp_err_s = 1'b1;
        end else if (!cur_we_s) begin
            resp_rdata_s = load_ext(rd_word_s, cur_func3_s, cur_addr_s[1:0]);
        end else begin
            resp_rdata_s = 32'h0000_0000;
        end
    end

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_r <= IDLE;
        else        state_r <= next_state_s;
    end

    // Next-state logic
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) next_state_s = (LATENCY == 1) ? RESP : BUSY;
                else          next_state_s = IDLE;
            end
            BUSY: begin
                if (cnt_r == 4'd0) next_state_s = RESP;
                else               next_state_s = BUSY;
            end
            RESP:    next_state_s = IDLE;
            default: next_state_s = IDLE;
        endcase
    end

    // Latency counter and latched request operands
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_r      <= 4'd0;
            sel_data_r <= 1'b0;
            we_r       <= 1'b0;
            func3_r    <= 3'b000;
            addr_r     <= '0;
            wdata_r    <= 32'h0000_0000;
        end else if (accept_s) begin
            cnt_r      <= 4'(LATENCY - 1);
            sel_data_r <= cur_data_s;
            we_r       <= cur_we_s;
            func3_r    <= cur_func3_s;
            addr_r     <= cur_addr_s;
            wdata_r    <= bus.data_wdata_ip;
        end else if (state_r == BUSY && cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Registered grants, error and read data; rdata of the non-granted port holds
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            instr_gnt_r   <= 1'b0;
            data_gnt_r    <= 1'b0;
            data_err_r    <= 1'b0;
            instr_rdata_r <= 32'h0000_0000;
            data_rdata_r  <= 32'h0000_0000;
        end else begin
            instr_gnt_r <= (next_state_s == RESP) && !cur_data_s;
            data_gnt_r  <= (next_state_s == RESP) &&  cur_data_s;
            data_err_r  <= (next_state_s == RESP) &&  cur_data_s && resp_err_s;
            if (next_state_s == RESP && cur_data_s)  data_rdata_r  <= resp_rdata_s;
            if (next_state_s == RESP && !cur_data_s) instr_rdata_r <= resp_rdata_s;
        end
    end

    assign wr_en_s   = (state_r == RESP) && sel_data_r && we_r && !access_err(1'b1, func3_r, addr_r[1:0]);
    assign wr_be_s   = store_be(func3_r, addr_r[1:0]);
    assign wr_mask_s = {{8{wr_be_s[3]}}, {8{wr_be_s[2]}}, {8{wr_be_s[1]}}, {8{wr_be_s[0]}}};
    assign wr_lane_s = store_lane(func3_r, wdata_r);

    // Store commit at the edge ending RESP; array is deliberately not reset
    always_ff @(posedge clock) begin
        if (wr_en_s && reset)
            mem_r[addr_r[AW+1:2]] <= (mem_r[addr_r[AW+1:2]] & ~wr_mask_s) | (wr_lane_s & wr_mask_s);
    end

    assign bus.instr_gnt_op   = instr_gnt_r;
    assign bus.instr_rdata_op = instr_rdata_r;
    assign bus.data_gnt_op    = data_gnt_r;
    assign bus.data_rdata_op  = data_rdata_r;
    assign bus.data_err_op    = data_err_r;
endmodule
